// File: rtl/memory_bus_arbiter_if.sv
// Bus bundle for memory_bus_arbiter: flattened upstream request/response lanes
// plus the single downstream port. umsLock exists only when ARBITER_LOCK_EN is defined.
interface memory_bus_arbiter_if #(
  parameter int NUM_MASTERS     = 4,
  parameter int DATA_WIDTH      = 24,
  parameter int ADDRESS_WIDTH   = 32,
  parameter int MASTER_ID_WIDTH = 8
) ();
  logic [NUM_MASTERS*MASTER_ID_WIDTH-1:0] umsID;
  logic [NUM_MASTERS*ADDRESS_WIDTH-1:0]   umsAddress;
  logic [NUM_MASTERS*DATA_WIDTH-1:0]      umsData;
  logic [NUM_MASTERS-1:0]                 umsWrite;
  logic [NUM_MASTERS-1:0]                 umsValid;
  logic [NUM_MASTERS-1:0]                 umsTaken;
`ifdef ARBITER_LOCK_EN
  logic [NUM_MASTERS-1:0]                 umsLock;
`endif
  logic [MASTER_ID_WIDTH-1:0]             usmID;
  logic [DATA_WIDTH-1:0]                  usmData;
  logic [NUM_MASTERS-1:0]                 usmValid;
  logic [NUM_MASTERS-1:0]                 usmTaken;
  logic [MASTER_ID_WIDTH-1:0]             dmsID;
  logic [ADDRESS_WIDTH-1:0]               dmsAddress;
  logic [DATA_WIDTH-1:0]                  dmsData;
  logic                                   dmsWrite;
  logic                                   dmsValid;
  logic                                   dmsTaken;
  logic [MASTER_ID_WIDTH-1:0]             dsmID;
  logic [DATA_WIDTH-1:0]                  dsmData;
  logic                                   dsmValid;
  logic                                   dsmTaken;
  logic                                   unroutedError;

  modport slave (
`ifdef ARBITER_LOCK_EN
    input  umsLock,
`endif
    input  umsID, umsAddress, umsData, umsWrite, umsValid, usmTaken,
    input  dmsTaken, dsmID, dsmData, dsmValid,
    output umsTaken, usmID, usmData, usmValid,
    output dmsID, dmsAddress, dmsData, dmsWrite, dmsValid, dsmTaken, unroutedError
  );

  modport master (
`ifdef ARBITER_LOCK_EN
    output umsLock,
`endif
    output umsID, umsAddress, umsData, umsWrite, umsValid, usmTaken,
    output dmsTaken, dsmID, dsmData, dsmValid,
    input  umsTaken, usmID, usmData, usmValid,
    input  dmsID, dmsAddress, dmsData, dmsWrite, dmsValid, dsmTaken, unroutedError
  );
endinterface

// File: rtl/memory_bus_arbiter.sv
// Round-robin arbiter sharing one downstream memory port among NUM_MASTERS masters,
// with ID-range response routing. Optional burst lock enabled by ARBITER_LOCK_EN.
module memory_bus_arbiter #(
  parameter int                         NUM_MASTERS     = 4,
  parameter int                         DATA_WIDTH      = 24,
  parameter int                         ADDRESS_WIDTH   = 32,
  parameter int                         MASTER_ID_WIDTH = 8,
  parameter logic [MASTER_ID_WIDTH-1:0] MASTER_ID_BASE  = 8'd4,
  parameter int                         IDS_PER_MASTER  = 4
) (
  input logic                 clock,
  input logic                 reset,
  memory_bus_arbiter_if.slave bus
);
  localparam int PW    = $clog2(NUM_MASTERS);
  localparam int SHIFT = $clog2(IDS_PER_MASTER);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} req_state_t;

  req_state_t                 state_reg, state_next;
  logic [PW-1:0]              ptr_reg, ptr_next;
  logic [MASTER_ID_WIDTH-1:0] dms_id_reg;
  logic [ADDRESS_WIDTH-1:0]   dms_addr_reg;
  logic [DATA_WIDTH-1:0]      dms_data_reg;
  logic                       dms_write_reg;

  logic [MASTER_ID_WIDTH-1:0] ms_id   [NUM_MASTERS];
  logic [ADDRESS_WIDTH-1:0]   ms_addr [NUM_MASTERS];
  logic [DATA_WIDTH-1:0]      ms_data [NUM_MASTERS];

  logic [NUM_MASTERS-1:0]     eligible;
  logic                       grant_found;
  logic [PW-1:0]              grant_idx;
  logic [PW-1:0]              cand;
  logic                       can_load;
  logic                       load;
  logic                       advance;

  for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_unpack
    assign ms_id[gi]   = bus.umsID[gi*MASTER_ID_WIDTH +: MASTER_ID_WIDTH];
    assign ms_addr[gi] = bus.umsAddress[gi*ADDRESS_WIDTH +: ADDRESS_WIDTH];
    assign ms_data[gi] = bus.umsData[gi*DATA_WIDTH +: DATA_WIDTH];
  end

`ifdef ARBITER_LOCK_EN
  logic                   lock_reg, lock_next;
  logic [PW-1:0]          owner_reg, owner_next;
  logic [NUM_MASTERS-1:0] owner_mask;

  for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_owner
    assign owner_mask[gi] = (owner_reg == PW'(gi));
  end

  // While a burst holds the lock, only its owner competes.
  assign eligible = lock_reg ? (bus.umsValid & owner_mask) : bus.umsValid;
  assign advance  = !bus.umsLock[grant_idx];

  always_comb begin
    lock_next  = lock_reg;
    owner_next = owner_reg;
    if (load) begin
      lock_next  = bus.umsLock[grant_idx];
      owner_next = grant_idx;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      lock_reg  <= 1'b0;
      owner_reg <= '0;
    end else begin
      lock_reg  <= lock_next;
      owner_reg <= owner_next;
    end
  end
`else
  assign eligible = bus.umsValid;
  assign advance  = 1'b1;
`endif

  // Descending scan so the candidate closest to the pointer is written last and wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
      cand = PW'((int'(ptr_reg) + k) % NUM_MASTERS);
      if (eligible[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  assign can_load = (state_reg == EMPTY) || bus.dmsTaken;
  assign load     = can_load && grant_found && !reset;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= EMPTY;
      ptr_reg       <= '0;
      dms_id_reg    <= '0;
      dms_addr_reg  <= '0;
      dms_data_reg  <= '0;
      dms_write_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      if (load) begin
        dms_id_reg    <= ms_id[grant_idx];
        dms_addr_reg  <= ms_addr[grant_idx];
        dms_data_reg  <= ms_data[grant_idx];
        dms_write_reg <= bus.umsWrite[grant_idx];
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    if (load) begin
      state_next = FULL;
      if (advance) begin
        ptr_next = (grant_idx == PW'(NUM_MASTERS - 1)) ? '0 : grant_idx + PW'(1);
      end
    end else if (state_reg == FULL && bus.dmsTaken) begin
      state_next = EMPTY;
    end
  end

  always_comb begin
    bus.dmsValid = (state_reg == FULL) && !reset;
    bus.umsTaken = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      bus.umsTaken[i] = load && (grant_idx == PW'(i));
    end
  end

  assign bus.dmsID      = dms_id_reg;
  assign bus.dmsAddress = dms_addr_reg;
  assign bus.dmsData    = dms_data_reg;
  assign bus.dmsWrite   = dms_write_reg;

  logic                       resp_valid_reg;
  logic [PW-1:0]              resp_dest_reg;
  logic [MASTER_ID_WIDTH-1:0] usm_id_reg;
  logic [DATA_WIDTH-1:0]      usm_data_reg;
  logic                       error_reg;

  logic [MASTER_ID_WIDTH-1:0] rel_id;
  logic [MASTER_ID_WIDTH-1:0] dest_wide;
  logic                       routable;
  logic                       drain;
  logic                       accept;

  // Unsigned subtraction wraps below the base, so the >= test guards that case.
  assign rel_id    = bus.dsmID - MASTER_ID_BASE;
  assign dest_wide = rel_id >> SHIFT;
  assign routable  = (bus.dsmID >= MASTER_ID_BASE) &&
                     (dest_wide < MASTER_ID_WIDTH'(NUM_MASTERS));
  assign drain     = resp_valid_reg && bus.usmTaken[resp_dest_reg];
  assign bus.dsmTaken = !reset && (!resp_valid_reg || bus.usmTaken[resp_dest_reg]);
  assign accept    = bus.dsmValid && bus.dsmTaken;

  always_ff @(posedge clock) begin
    if (reset) begin
      resp_valid_reg <= 1'b0;
      resp_dest_reg  <= '0;
      usm_id_reg     <= '0;
      usm_data_reg   <= '0;
      error_reg      <= 1'b0;
    end else begin
      if (accept && routable) begin
        resp_valid_reg <= 1'b1;
        resp_dest_reg  <= dest_wide[PW-1:0];
        usm_id_reg     <= bus.dsmID;
        usm_data_reg   <= bus.dsmData;
      end else if (drain) begin
        resp_valid_reg <= 1'b0;
      end
      if (accept && !routable) begin
        error_reg <= 1'b1;
      end
    end
  end

  for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_usm_valid
    assign bus.usmValid[gi] = resp_valid_reg && !reset && (resp_dest_reg == PW'(gi));
  end

  assign bus.usmID         = usm_id_reg;
  assign bus.usmData       = usm_data_reg;
  assign bus.unroutedError = error_reg;
endmodule

// File: tb/tb_memory_bus_arbiter.sv
// Scoreboard bench for memory_bus_arbiter: expected downstream requests and
// routed responses are queued as stimulus is driven and popped as the DUT emits them.
`timescale 1ns/1ps
module tb_memory_bus_arbiter;
  localparam int NM = 4;
  localparam int DW = 24;
  localparam int AW = 32;
  localparam int IW = 8;

  typedef struct packed {
    logic [IW-1:0] id;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          wr;
  } req_t;

  typedef struct packed {
    logic [1:0]    dest;
    logic [IW-1:0] id;
    logic [DW-1:0] data;
  } rsp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;
  req_t cur_req [NM];
  req_t req_q[$];
  rsp_t rsp_q[$];

  memory_bus_arbiter_if #(
    .NUM_MASTERS(NM), .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .MASTER_ID_WIDTH(IW)
  ) bus ();

  memory_bus_arbiter #(
    .NUM_MASTERS(NM), .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .MASTER_ID_WIDTH(IW),
    .MASTER_ID_BASE(8'd4), .IDS_PER_MASTER(4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_master(input int i, input logic [IW-1:0] id, input logic [AW-1:0] addr,
                            input logic [DW-1:0] data, input logic wr);
    bus.umsID[i*IW +: IW]      = id;
    bus.umsAddress[i*AW +: AW] = addr;
    bus.umsData[i*DW +: DW]    = data;
    bus.umsWrite[i]            = wr;
    cur_req[i]                 = {id, addr, data, wr};
  endtask

  task automatic test_reset();
    for (int i = 0; i < NM; i++) set_master(i, 8'(8'h10 + i), 32'hA000_0000 + 32'(i * 16),
                                            24'(24'h000100 + i), 1'(i % 2));
    bus.umsValid = 4'hF;
    bus.usmTaken = 4'h0;
    bus.dmsTaken = 1'b1;
    bus.dsmValid = 1'b1;
    bus.dsmID    = 8'd3;
    bus.dsmData  = 24'h0;
`ifdef ARBITER_LOCK_EN
    bus.umsLock  = 4'h0;
`endif
    reset = 1'b1;
    step();
    @(negedge clock);
    checks++;
    if (bus.umsTaken !== 4'b0 || bus.dsmTaken !== 1'b0)
      $display("FAIL reset_taken got ums=%b dsm=%b exp ums=0000 dsm=0", bus.umsTaken, bus.dsmTaken);
    checks++;
    if (bus.dmsValid !== 1'b0 || bus.usmValid !== 4'b0 || bus.unroutedError !== 1'b0) begin
      failures++;
      $display("FAIL reset_valid got dmsValid=%b usmValid=%b err=%b exp 0/0000/0",
               bus.dmsValid, bus.usmValid, bus.unroutedError);
    end
    checks++;
    if ({bus.dmsID, bus.dmsAddress, bus.dmsData, bus.dmsWrite, bus.usmID, bus.usmData} !== '0) begin
      failures++;
      $display("FAIL reset_regs got dmsID=%h dmsAddr=%h dmsData=%h usmID=%h usmData=%h exp all 0",
               bus.dmsID, bus.dmsAddress, bus.dmsData, bus.usmID, bus.usmData);
    end
    if (bus.umsTaken !== 4'b0 || bus.dsmTaken !== 1'b0) failures++;
    step();
    bus.dsmValid = 1'b0;
    bus.umsValid = 4'h0;
    reset = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_taken;
    req_t got, exp;
    bus.umsValid = 4'hF;
    bus.dmsTaken = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (c >= 8) bus.umsValid = 4'h0;
      @(negedge clock);
      exp_taken = (c < 8) ? (4'b0001 << (c % 4)) : 4'b0000;
      checks++;
      if (bus.umsTaken !== exp_taken) begin
        failures++;
        $display("FAIL rr_taken cyc=%0d got=%b exp=%b", c, bus.umsTaken, exp_taken);
      end
      checks++;
      if (bus.dmsValid !== (c >= 1 && c <= 8)) begin
        failures++;
        $display("FAIL rr_dmsValid cyc=%0d got=%b exp=%b", c, bus.dmsValid, (c >= 1 && c <= 8));
      end
      if (bus.dmsValid === 1'b1 && bus.dmsTaken === 1'b1) begin
        checks++;
        got = {bus.dmsID, bus.dmsAddress, bus.dmsData, bus.dmsWrite};
        if (req_q.size() == 0) begin
          failures++;
          $display("FAIL rr_unexpected cyc=%0d got=%h exp=none", c, got);
        end else begin
          exp = req_q.pop_front();
          if (got !== exp) begin
            failures++;
            $display("FAIL rr_dms cyc=%0d got=%h exp=%h", c, got, exp);
          end
        end
      end
      if (c < 8) req_q.push_back(cur_req[c % 4]);
      step();
    end
  endtask

  task automatic test_hold();
    req_t got, exp;
    bus.umsValid = 4'b0100;
    bus.dmsTaken = 1'b0;
    @(negedge clock);
    checks++;
    if (bus.umsTaken !== 4'b0100 || bus.dmsValid !== 1'b0) begin
      failures++;
      $display("FAIL hold_first got taken=%b dmsValid=%b exp 0100/0", bus.umsTaken, bus.dmsValid);
    end
    req_q.push_back(cur_req[2]);
    step();
    set_master(2, 8'h22, 32'hBEEF_0002, 24'h00C0DE, 1'b1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      got = {bus.dmsID, bus.dmsAddress, bus.dmsData, bus.dmsWrite};
      exp = req_q[0];
      checks++;
      if (bus.umsTaken !== 4'b0000 || bus.dmsValid !== 1'b1 || got !== exp) begin
        failures++;
        $display("FAIL hold_stable cyc=%0d got taken=%b valid=%b dms=%h exp 0000/1/%h",
                 c, bus.umsTaken, bus.dmsValid, got, exp);
      end
      step();
    end
    bus.dmsTaken = 1'b1;
    for (int c = 0; c < 3; c++) begin
      if (c == 1) bus.umsValid = 4'b0000;
      @(negedge clock);
      checks++;
      if (bus.umsTaken !== ((c == 0) ? 4'b0100 : 4'b0000)) begin
        failures++;
        $display("FAIL hold_taken cyc=%0d got=%b exp=%b", c, bus.umsTaken,
                 (c == 0) ? 4'b0100 : 4'b0000);
      end
      checks++;
      if (bus.dmsValid !== (c < 2)) begin
        failures++;
        $display("FAIL hold_valid cyc=%0d got=%b exp=%b", c, bus.dmsValid, (c < 2));
      end
      if (bus.dmsValid === 1'b1) begin
        checks++;
        got = {bus.dmsID, bus.dmsAddress, bus.dmsData, bus.dmsWrite};
        exp = (req_q.size() > 0) ? req_q.pop_front() : '0;
        if (got !== exp) begin
          failures++;
          $display("FAIL hold_dms cyc=%0d got=%h exp=%h", c, got, exp);
        end
      end
      if (c == 0) req_q.push_back(cur_req[2]);
      step();
    end
  endtask

  task automatic test_response_route();
    int         v_t  [6] = '{1, 1, 1, 1, 0, 0};
    logic [7:0] id_t [6] = '{8'd9, 8'd4, 8'd13, 8'd13, 8'd0, 8'd0};
    logic [23:0] d_t [6] = '{24'h0ABCDE, 24'h111111, 24'h222222, 24'h222222, 24'h0, 24'h0};
    logic [3:0] ut_t [6] = '{4'b0010, 4'b0010, 4'b0010, 4'b0001, 4'b0100, 4'b0000};
    logic [1:0] dst_t[6] = '{2'd1, 2'd0, 2'd2, 2'd2, 2'd0, 2'd0};
    int         dt_t [6] = '{1, 1, 0, 1, 1, 1};
    rsp_t       exp;
    logic [3:0] oh;
    for (int c = 0; c < 6; c++) begin
      bus.dsmValid = (v_t[c] != 0);
      bus.dsmID    = id_t[c];
      bus.dsmData  = d_t[c];
      bus.usmTaken = ut_t[c];
      @(negedge clock);
      checks++;
      if (bus.dsmTaken !== (dt_t[c] != 0)) begin
        failures++;
        $display("FAIL route_dsmTaken cyc=%0d got=%b exp=%b", c, bus.dsmTaken, (dt_t[c] != 0));
      end
      checks++;
      if (rsp_q.size() > 0) begin
        exp = rsp_q[0];
        oh  = 4'b0001 << exp.dest;
        if (bus.usmValid !== oh || bus.usmID !== exp.id || bus.usmData !== exp.data) begin
          failures++;
          $display("FAIL route_usm cyc=%0d got v=%b id=%h d=%h exp v=%b id=%h d=%h", c,
                   bus.usmValid, bus.usmID, bus.usmData, oh, exp.id, exp.data);
        end
        if (ut_t[c][exp.dest]) void'(rsp_q.pop_front());
      end else if (bus.usmValid !== 4'b0000) begin
        failures++;
        $display("FAIL route_idle cyc=%0d got=%b exp=0000", c, bus.usmValid);
      end
      if (v_t[c] != 0 && dt_t[c] != 0) rsp_q.push_back({dst_t[c], id_t[c], d_t[c]});
      step();
    end
  endtask

  task automatic test_unrouted();
    int         v_t  [5] = '{1, 1, 1, 0, 0};
    logic [7:0] id_t [5] = '{8'd3, 8'd20, 8'd19, 8'd0, 8'd0};
    int         rt_t [5] = '{0, 0, 1, 0, 0};
    logic [3:0] ut_t [5] = '{4'b0000, 4'b0000, 4'b1000, 4'b1000, 4'b0000};
    int         er_t [5] = '{0, 1, 1, 1, 1};
    rsp_t       exp;
    logic [3:0] oh;
    for (int c = 0; c < 5; c++) begin
      bus.dsmValid = (v_t[c] != 0);
      bus.dsmID    = id_t[c];
      bus.dsmData  = 24'h5A0000 + 24'(c);
      bus.usmTaken = ut_t[c];
      @(negedge clock);
      checks++;
      if (bus.dsmTaken !== 1'b1 || bus.unroutedError !== (er_t[c] != 0)) begin
        failures++;
        $display("FAIL unrouted cyc=%0d got taken=%b err=%b exp 1/%b", c, bus.dsmTaken,
                 bus.unroutedError, (er_t[c] != 0));
      end
      checks++;
      if (rsp_q.size() > 0) begin
        exp = rsp_q[0];
        oh  = 4'b0001 << exp.dest;
        if (bus.usmValid !== oh || bus.usmID !== exp.id || bus.usmData !== exp.data) begin
          failures++;
          $display("FAIL unrouted_usm cyc=%0d got v=%b id=%h exp v=%b id=%h", c,
                   bus.usmValid, bus.usmID, oh, exp.id);
        end
        if (ut_t[c][exp.dest]) void'(rsp_q.pop_front());
      end else if (bus.usmValid !== 4'b0000) begin
        failures++;
        $display("FAIL unrouted_idle cyc=%0d got=%b exp=0000", c, bus.usmValid);
      end
      if (v_t[c] != 0 && rt_t[c] != 0) rsp_q.push_back({2'd3, id_t[c], 24'h5A0000 + 24'(c)});
      step();
    end
  endtask

  task automatic test_reset_mid();
    req_t got, exp;
    bus.umsValid = 4'b0010;
    bus.dmsTaken = 1'b0;
    bus.dsmValid = 1'b1;
    bus.dsmID    = 8'd5;
    bus.dsmData  = 24'h777777;
    bus.usmTaken = 4'b0000;
    @(negedge clock);
    checks++;
    if (bus.umsTaken !== 4'b0010 || bus.dsmTaken !== 1'b1) begin
      failures++;
      $display("FAIL mid_load got taken=%b dsmTaken=%b exp 0010/1", bus.umsTaken, bus.dsmTaken);
    end
    req_q.push_back(cur_req[1]);
    step();
    bus.umsValid = 4'b1010;
    bus.dsmValid = 1'b0;
    @(negedge clock);
    checks++;
    if (bus.dmsValid !== 1'b1 || bus.usmValid !== 4'b0001 || bus.usmID !== 8'd5) begin
      failures++;
      $display("FAIL mid_held got dmsValid=%b usmValid=%b usmID=%h exp 1/0001/05",
               bus.dmsValid, bus.usmValid, bus.usmID);
    end
    step();
    reset = 1'b1;
    bus.dmsTaken = 1'b1;
    bus.usmTaken = 4'hF;
    @(negedge clock);
    checks++;
    if (bus.umsTaken !== 4'b0000 || bus.dsmTaken !== 1'b0) begin
      failures++;
      $display("FAIL mid_in_reset got taken=%b dsmTaken=%b exp 0000/0", bus.umsTaken, bus.dsmTaken);
    end
    step();
    reset = 1'b0;
    bus.dmsTaken = 1'b0;
    req_q.delete();
    rsp_q.delete();
    @(negedge clock);
    checks++;
    if (bus.dmsValid !== 1'b0 || bus.usmValid !== 4'b0 || bus.unroutedError !== 1'b0) begin
      failures++;
      $display("FAIL mid_after got dmsValid=%b usmValid=%b err=%b exp 0/0000/0",
               bus.dmsValid, bus.usmValid, bus.unroutedError);
    end
    checks++;
    if (bus.umsTaken !== 4'b0010) begin
      failures++;
      $display("FAIL mid_first_grant got=%b exp=0010", bus.umsTaken);
    end
    req_q.push_back(cur_req[1]);
    step();
    bus.umsValid = 4'b0000;
    bus.dmsTaken = 1'b1;
    @(negedge clock);
    checks++;
    got = {bus.dmsID, bus.dmsAddress, bus.dmsData, bus.dmsWrite};
    exp = (req_q.size() > 0) ? req_q.pop_front() : '0;
    if (bus.dmsValid !== 1'b1 || got !== exp) begin
      failures++;
      $display("FAIL mid_dms got valid=%b dms=%h exp 1/%h", bus.dmsValid, got, exp);
    end
    step();
  endtask

`ifdef ARBITER_LOCK_EN
  task automatic test_lock();
    req_t got, exp;
    int   g;
    bus.dmsTaken = 1'b1;
    bus.umsValid = 4'b0001;
    bus.umsLock  = 4'b0000;
    @(negedge clock);
    checks++;
    if (bus.umsTaken !== 4'b0001) begin
      failures++;
      $display("FAIL lock_pre got=%b exp=0001", bus.umsTaken);
    end
    req_q.push_back(cur_req[0]);
    step();
    for (int b = 0; b < 5; b++) begin
      set_master(1, 8'(8'h30 + b), 32'hC000_0000 + 32'(b), 24'(24'h0B0000 + b), 1'b0);
      bus.umsLock  = (b < 2) ? 4'b0010 : 4'b0000;
      bus.umsValid = (b < 4) ? 4'b0011 : 4'b0000;
      g = (b < 3) ? 1 : 0;
      @(negedge clock);
      checks++;
      if (bus.umsTaken !== ((b < 4) ? (4'b0001 << g) : 4'b0000)) begin
        failures++;
        $display("FAIL lock_grant beat=%0d got=%b exp=%b", b, bus.umsTaken,
                 (b < 4) ? (4'b0001 << g) : 4'b0000);
      end
      if (bus.dmsValid === 1'b1) begin
        checks++;
        got = {bus.dmsID, bus.dmsAddress, bus.dmsData, bus.dmsWrite};
        exp = (req_q.size() > 0) ? req_q.pop_front() : '0;
        if (got !== exp) begin
          failures++;
          $display("FAIL lock_dms beat=%0d got=%h exp=%h", b, got, exp);
        end
      end
      if (b < 4) req_q.push_back(cur_req[g]);
      step();
    end
  endtask
`endif

  initial begin
    test_reset();
    test_round_robin();
    test_hold();
    test_response_route();
    test_unrouted();
    test_reset_mid();
`ifdef ARBITER_LOCK_EN
    test_lock();
`endif
    checks++;
    if (req_q.size() != 0 || rsp_q.size() != 0) begin
      failures++;
      $display("FAIL leftover got req=%0d rsp=%0d exp 0/0", req_q.size(), rsp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
